// File: rtl/vc_mem_arbiter.sv
// Round-robin arbiter sharing one external memory port between icache line fills and dcache accesses.
// Optional macro ARB_TIMEOUT_EN aborts a transaction that sees no mem_ack for TIMEOUT cycles.
module vc_mem_arbiter #(
    parameter int PA         = 24,
    parameter int DW         = 16,
    parameter int LINE_BEATS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_req,
    input  logic [PA-1:0]                 i_addr,
    output logic [DW-1:0]                 i_rdata,
    output logic                          i_rvalid,
    output logic [$clog2(LINE_BEATS)-1:0] i_beat,
    output logic                          i_done,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic                          d_line,
    input  logic [PA-1:0]                 d_addr,
    input  logic [DW-1:0]                 d_wdata,
    output logic                          d_wnext,
    output logic [DW-1:0]                 d_rdata,
    output logic                          d_rvalid,
    output logic [$clog2(LINE_BEATS)-1:0] d_beat,
    output logic                          d_done,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [PA-1:0]                 mem_addr,
    output logic [DW-1:0]                 mem_wdata,
    input  logic [DW-1:0]                 mem_rdata,
    input  logic                          mem_ack,
    output logic                          bus_err
);

    localparam int            B         = $clog2(LINE_BEATS);
    localparam logic [B-1:0]  LAST_BEAT = B'(LINE_BEATS - 1);
    localparam logic [PA-1:0] LINE_MASK = PA'(2 * LINE_BEATS - 1);

    if (LINE_BEATS < 2 || (LINE_BEATS & (LINE_BEATS - 1)) != 0) begin : g_bad_line
        $error("LINE_BEATS must be a power of 2 and at least 2");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("TIMEOUT must fit the 8-bit abort counter (1..255)");
    end

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;
    state_t state, state_next;

    logic          gnt_d;
    logic          last_d;
    logic          we_q;
    logic          line_q;
    logic [PA-1:0] addr_q;
    logic [B-1:0]  beat;
    logic          grant;
    logic          grant_d;
    logic          finish;
    logic          abort;
    logic          last_beat;
    logic          timeout_hit;
    logic          active;

    // Line bursts wrap the beat index inside the line; single beats only clear the byte bit.
    function automatic logic [PA-1:0] beat_addr(input logic [PA-1:0] a, input logic [B-1:0] bt,
                                                input logic line);
        logic [PA-1:0] off;
        off      = '0;
        off[B:1] = bt;
        return line ? ((a & ~LINE_MASK) | off) : (a & ~PA'(1));
    endfunction

    assign active    = (state == XFER);
    assign last_beat = !line_q || (beat == LAST_BEAT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_d    = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    grant      = 1'b1;
                    grant_d    = d_req && (!i_req || !last_d);
                    state_next = XFER;
                end
            end
            XFER: begin
                if (mem_ack && last_beat) begin
                    finish     = 1'b1;
                    state_next = DONE;
                end else if (timeout_hit) begin
                    abort      = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] tmo_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 tmo_cnt <= '0;
        else if (grant || mem_ack) tmo_cnt <= '0;
        else if (active)           tmo_cnt <= tmo_cnt + 8'd1;
    end

    assign timeout_hit = active && !mem_ack && (tmo_cnt == TMO_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt_d    <= 1'b0;
            last_d   <= 1'b0;
            beat     <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            i_done   <= 1'b0;
            d_done   <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            if (grant) begin
                gnt_d    <= grant_d;
                beat     <= '0;
                mem_req  <= 1'b1;
                mem_we   <= grant_d && d_we;
                mem_addr <= grant_d ? beat_addr(d_addr, '0, d_line) : beat_addr(i_addr, '0, 1'b1);
            end else if (active && mem_ack) begin
                beat     <= finish ? '0 : beat + 1'b1;
                mem_addr <= beat_addr(addr_q, beat + 1'b1, line_q);
            end
            if (finish || abort) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                last_d  <= gnt_d;
            end
            i_done  <= (finish || abort) && !gnt_d;
            d_done  <= (finish || abort) && gnt_d;
            bus_err <= abort;
        end
    end

    // Transaction attributes are frozen at grant; later request-side changes are ignored.
    always_ff @(posedge clk) begin
        if (grant) begin
            addr_q <= grant_d ? d_addr : i_addr;
            we_q   <= grant_d && d_we;
            line_q <= !grant_d || d_line;
        end
    end

    assign i_rvalid  = active && !gnt_d && mem_ack;
    assign d_rvalid  = active && gnt_d && !we_q && mem_ack;
    assign d_wnext   = active && gnt_d && we_q && mem_ack;
    assign i_rdata   = (active && !gnt_d) ? mem_rdata : '0;
    assign d_rdata   = (active && gnt_d && !we_q) ? mem_rdata : '0;
    assign i_beat    = (active && !gnt_d) ? beat : '0;
    assign d_beat    = (active && gnt_d) ? beat : '0;
    assign mem_wdata = (active && gnt_d && we_q) ? d_wdata : '0;

endmodule

// File: tb/tb_vc_mem_arbiter.sv
// Scoreboard bench for vc_mem_arbiter: expected beats, read data and done pulses are queued at
// stimulus time and retired as the arbiter produces them. Build with ARB_TIMEOUT_EN for the abort case.
module tb_vc_mem_arbiter;

    typedef struct packed {
        logic        side;
        logic [1:0]  idx;
        logic [23:0] addr;
        logic        we;
        logic [15:0] wdata;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [23:0] i_addr = '0;
    logic [15:0] i_rdata;
    logic        i_rvalid;
    logic [1:0]  i_beat;
    logic        i_done;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic        d_line = 1'b0;
    logic [23:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_wnext;
    logic [15:0] d_rdata;
    logic        d_rvalid;
    logic [1:0]  d_beat;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        bus_err;

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    logic ack_en = 1'b1;
    logic ack_force = 1'b0;
    logic wnext_seen = 1'b0;
    int req_cycles = 0;
    int wnext_cnt = 0;
    int rv_cnt = 0;

    beat_t       q_beat[$];
    logic [16:0] q_rd[$];
    logic [1:0]  q_done[$];
    beat_t       mb;
    logic [16:0] mr;
    logic [1:0]  md;

    vc_mem_arbiter #(.PA(24), .DW(16), .LINE_BEATS(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
        .i_beat(i_beat), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_line(d_line), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wnext(d_wnext), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_beat(d_beat), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_model(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], 8'h3C};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic push_xfer(input logic side, input logic [23:0] addr, input logic we,
                             input logic line, input logic [15:0] wbase, input int nbeats,
                             input logic done, input logic err);
        for (int k = 0; k < nbeats; k++) begin
            beat_t b;
            b.side  = side;
            b.idx   = 2'(k);
            b.addr  = line ? ((addr & ~24'h7) | 24'(k * 2)) : (addr & ~24'h1);
            b.we    = we;
            b.wdata = we ? wbase + 16'(k * 16'h0101) : 16'h0;
            q_beat.push_back(b);
            if (!we) q_rd.push_back({side, mem_model(b.addr)});
        end
        if (done) q_done.push_back({side, err});
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(i_done || d_done) && n < budget);
        chk("done_in_time", 32'(i_done || d_done), 1);
    endtask

    task automatic do_reset;
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_done", 32'({i_done, d_done, bus_err}), 0);
        chk("rst_comb", 32'({i_rvalid, d_rvalid, d_wnext}), 0);
        #2 reset = 1'b0;
    endtask

    // Memory responder: acks after ack_delay wait cycles per beat, advances write data on d_wnext.
    always @(posedge clk) begin
        #1;
        if (wnext_seen) begin
            d_wdata    = d_wdata + 16'h0101;
            wnext_seen = 1'b0;
        end
        mem_ack   = ack_force || (mem_req && ack_en && wait_cnt == ack_delay);
        mem_rdata = mem_model(mem_addr);
        if (mem_ack || !mem_req) wait_cnt = 0;
        else                     wait_cnt = wait_cnt + 1;
    end

    always @(negedge clk) begin
        if (mem_req) req_cycles++;
        if (d_wnext) begin
            wnext_cnt++;
            wnext_seen = 1'b1;
        end
        if (mem_req && mem_ack) begin
            chk("beat_expected", 32'(q_beat.size() != 0), 1);
            if (q_beat.size() != 0) begin
                mb = q_beat.pop_front();
                chk("mem_addr", 32'(mem_addr), 32'(mb.addr));
                chk("mem_we", 32'(mem_we), 32'(mb.we));
                if (mb.we) chk("mem_wdata", 32'(mem_wdata), 32'(mb.wdata));
                chk("beat_idx", 32'(mb.side ? d_beat : i_beat), 32'(mb.idx));
                chk("wnext", 32'(d_wnext), 32'(mb.we));
            end
        end
        if (i_rvalid || d_rvalid) begin
            rv_cnt++;
            chk("rvalid_both", 32'(i_rvalid && d_rvalid), 0);
            chk("rd_expected", 32'(q_rd.size() != 0), 1);
            if (q_rd.size() != 0) begin
                mr = q_rd.pop_front();
                chk("rd_side", 32'(d_rvalid), 32'(mr[16]));
                chk("rdata", 32'(d_rvalid ? d_rdata : i_rdata), 32'(mr[15:0]));
            end
        end
        if (i_done || d_done) begin
            chk("done_both", 32'(i_done && d_done), 0);
            chk("done_expected", 32'(q_done.size() != 0), 1);
            if (q_done.size() != 0) begin
                md = q_done.pop_front();
                chk("done_side", 32'(d_done), 32'(md[1]));
                chk("bus_err", 32'(bus_err), 32'(md[0]));
            end
        end else if (bus_err) begin
            chk("bus_err_stray", 32'(bus_err), 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog at %0t: bench did not finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset;

        // acks with no transaction in flight must be ignored
        @(posedge clk); #1 ack_force = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ack_req", 32'(mem_req), 0);
        chk("idle_ack_rv", 32'({i_rvalid, d_rvalid, i_done, d_done}), 0);
        @(posedge clk); #1 ack_force = 1'b0;
        @(posedge clk);

        // icache line fill, ack every cycle
        #1 i_req = 1'b1; i_addr = 24'h001236; rv_cnt = 0;
        push_xfer(1'b0, 24'h001236, 1'b0, 1'b1, 16'h0, 4, 1'b1, 1'b0);
        @(negedge clk);
        chk("t1_req_latency", 32'(mem_req), 0);
        @(negedge clk);
        chk("t1_req_rise", 32'(mem_req), 1);
        chk("t1_first_addr", 32'(mem_addr), 32'h001230);
        wait_done(40);
        chk("t1_i_done", 32'(i_done), 1);
        chk("t1_req_low_at_done", 32'(mem_req), 0);
        chk("t1_rv_cnt", 32'(rv_cnt), 4);
        @(posedge clk); #1 i_req = 1'b0;
        @(negedge clk);
        chk("t1_done_one_cycle", 32'(i_done), 0);

        // simultaneous requests after reset: D wins, I follows after one idle cycle
        do_reset;
        @(posedge clk);
        #1 i_req = 1'b1; i_addr = 24'h000100;
        d_req = 1'b1; d_we = 1'b0; d_line = 1'b1; d_addr = 24'h000040;
        push_xfer(1'b1, 24'h000040, 1'b0, 1'b1, 16'h0, 4, 1'b1, 1'b0);
        push_xfer(1'b0, 24'h000100, 1'b0, 1'b1, 16'h0, 4, 1'b1, 1'b0);
        wait_done(40);
        chk("t2_d_first", 32'(d_done), 1);
        @(posedge clk); #1 d_req = 1'b0;
        @(negedge clk);
        chk("t2_idle_gap", 32'(mem_req), 0);
        @(negedge clk);
        chk("t2_i_granted", 32'(mem_req), 1);
        chk("t2_i_addr", 32'(mem_addr), 32'h000100);
        wait_done(40);
        chk("t2_i_done", 32'(i_done), 1);
        @(posedge clk); #1 i_req = 1'b0;

        // single-beat write with a 3-cycle ack delay
        @(posedge clk);
        #1 ack_delay = 3; req_cycles = 0; wnext_cnt = 0;
        d_req = 1'b1; d_we = 1'b1; d_line = 1'b0; d_addr = 24'h00ABCD; d_wdata = 16'h5A5A;
        push_xfer(1'b1, 24'h00ABCD, 1'b1, 1'b0, 16'h5A5A, 1, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        chk("t3_mem_we", 32'(mem_we), 1);
        chk("t3_mem_addr", 32'(mem_addr), 32'h00ABCC);
        chk("t3_mem_wdata", 32'(mem_wdata), 32'h5A5A);
        wait_done(40);
        chk("t3_d_done", 32'(d_done), 1);
        chk("t3_req_cycles", 32'(req_cycles), 4);
        chk("t3_wnext_cnt", 32'(wnext_cnt), 1);
        @(posedge clk); #1 d_req = 1'b0;

        // write line burst, new d_wdata presented after each d_wnext
        @(posedge clk);
        #1 ack_delay = 1; wnext_cnt = 0;
        d_req = 1'b1; d_we = 1'b1; d_line = 1'b1; d_addr = 24'h000A5F; d_wdata = 16'h1111;
        push_xfer(1'b1, 24'h000A5F, 1'b1, 1'b1, 16'h1111, 4, 1'b1, 1'b0);
        wait_done(60);
        chk("t3b_wnext_cnt", 32'(wnext_cnt), 4);
        @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0; ack_delay = 0;

        // reset in the middle of an icache fill, then restart from beat 0
        @(posedge clk);
        #1 i_req = 1'b1; i_addr = 24'h002000;
        push_xfer(1'b0, 24'h002000, 1'b0, 1'b1, 16'h0, 3, 1'b0, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req && mem_addr == 24'h002004) && n < 10);
        chk("t4_reach_beat2", 32'(mem_req && mem_addr == 24'h002004), 1);
        #2 reset = 1'b1;
        #1;
        chk("t4_req_async_low", 32'(mem_req), 0);
        chk("t4_no_done", 32'({i_done, d_done}), 0);
        push_xfer(1'b0, 24'h002000, 1'b0, 1'b1, 16'h0, 4, 1'b1, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        wait_done(40);
        chk("t4_restart_done", 32'(i_done), 1);
        @(posedge clk); #1 i_req = 1'b0;

`ifdef ARB_TIMEOUT_EN
        // D read never acked: abort after TIMEOUT cycles, pending I granted next
        do_reset;
        @(posedge clk);
        #1 ack_en = 1'b0; req_cycles = 0;
        d_req = 1'b1; d_we = 1'b0; d_line = 1'b0; d_addr = 24'h000300;
        i_req = 1'b1; i_addr = 24'h000400;
        push_xfer(1'b1, 24'h000300, 1'b0, 1'b0, 16'h0, 0, 1'b1, 1'b1);
        push_xfer(1'b0, 24'h000400, 1'b0, 1'b1, 16'h0, 4, 1'b1, 1'b0);
        wait_done(40);
        chk("t5_d_abort_done", 32'(d_done), 1);
        chk("t5_bus_err", 32'(bus_err), 1);
        chk("t5_xfer_cycles", 32'(req_cycles), 8);
        @(posedge clk); #1 d_req = 1'b0; ack_en = 1'b1;
        wait_done(40);
        chk("t5_i_after_abort", 32'(i_done), 1);
        @(posedge clk); #1 i_req = 1'b0;
`endif

        repeat (3) @(negedge clk);
        chk("q_beat_empty", 32'(q_beat.size()), 0);
        chk("q_rd_empty", 32'(q_rd.size()), 0);
        chk("q_done_empty", 32'(q_done.size()), 0);
        chk("end_idle", 32'(mem_req), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
